// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Provides the wrap/saturate mode enum and the default terminal value.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Largest value representable in w bits; default terminal value.
    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/updown_counter_n_next.sv
// Combinational next-count and overflow/underflow calculator.
// In: out, step, inc. Out: nxt, ovf_n, unf_n. MODE/MAX_VAL are params.
module updown_counter_n_next
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = cnt_max(WIDTH),
    parameter cnt_mode_e       MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] step,
    input  logic             inc,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf_n,
    output logic             unf_n
);

    localparam logic [WIDTH:0] MAXV = MAX_VAL[WIDTH:0];
    // Modulus fits WIDTH+1 bits because MAX_VAL <= 2**WIDTH-1.
    localparam logic [WIDTH:0] MODV = MAXV + 1'b1;

    logic [WIDTH:0] o_w;
    logic [WIDTH:0] s_w;
    logic [WIDTH:0] t_w;

    assign o_w = {1'b0, out};
    assign s_w = {1'b0, step};

    always_comb begin
        t_w   = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (inc) begin
            t_w = o_w + s_w;
            if (t_w > MAXV) begin
                ovf_n = 1'b1;
                if (MODE == CNT_SAT) t_w = MAXV;
                else                 t_w = t_w - MODV;
            end
        end else if (s_w <= o_w) begin
            t_w = o_w - s_w;
        end else begin
            unf_n = 1'b1;
            // out + MOD - step stays below 2**(WIDTH+1).
            if (MODE == CNT_SAT) t_w = '0;
            else                 t_w = o_w + MODV - s_w;
        end
        nxt = t_w[WIDTH-1:0];
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter: wrap/saturate, compare, event pulses.
// Ports: clk, rst (async high), clear, load/datain, counten, inc, step,
// cmp_we/cmp_in; out, tc (comb), ovf/unf/match (registered pulses).
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = cnt_max(WIDTH),
    parameter cnt_mode_e       MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] datain,
    input  logic             counten,
    input  logic             inc,
    input  logic [WIDTH-1:0] step,
    input  logic             cmp_we,
    input  logic [WIDTH-1:0] cmp_in,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             match
);

    localparam logic [WIDTH:0]   MAXV = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH-1:0] MAXW = MAXV[WIDTH-1:0];

    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] nxt;
    logic             ovf_n;
    logic             unf_n;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] cmp_val;

    updown_counter_n_next #(
        .WIDTH  (WIDTH),
        .MAX_VAL(MAX_VAL),
        .MODE   (MODE)
    ) u_next (
        .out  (out),
        .step (step),
        .inc  (inc),
        .nxt  (nxt),
        .ovf_n(ovf_n),
        .unf_n(unf_n)
    );

    assign ld_val  = ({1'b0, datain} > MAXV) ? MAXW : datain;
    assign cmp_val = ({1'b0, cmp_in} > MAXV) ? MAXW : cmp_in;

    assign tc = (inc && out == MAXW) || (!inc && out == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            match <= 1'b0;
            cmp   <= MAXW;
        end else begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            match <= 1'b0;
            if (clear) begin
                out <= '0;
            end else if (load) begin
                out <= ld_val;
            end else if (counten) begin
                out   <= nxt;
                ovf   <= ovf_n;
                unf   <= unf_n;
                // Compares against the pre-write cmp value.
                match <= (nxt == cmp);
            end
            if (cmp_we) cmp <= cmp_val;
        end
    end

    step_legal: assert property (
        @(posedge clk) disable iff (rst)
        (counten && !clear && !load) |-> ({1'b0, step} <= MAXV)
    ) else $error("updown_counter_n: step exceeds MAX_VAL");

endmodule

// File: tb/tb_updown_counter_n.sv
// Randomised bench for updown_counter_n against an arithmetic model.
// Three instances (WRAP 0..9, SAT 0..9, WRAP 0..15) share one stimulus.
module tb_updown_counter_n;
    import counter_pkg::*;

    localparam int N = 3;
    localparam int MAXS [N] = '{9, 9, 15};
    localparam bit SATS [N] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, load, counten, inc, cmp_we;
    logic [3:0] datain, step, cmp_in;
    logic [3:0] q    [N];
    logic       tc   [N];
    logic       ovf  [N];
    logic       unf  [N];
    logic       mtch [N];

    int m_out [N];
    int m_cmp [N];
    int m_ovf [N];
    int m_unf [N];
    int m_mat [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_WRAP)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .datain(datain), .counten(counten), .inc(inc), .step(step),
        .cmp_we(cmp_we), .cmp_in(cmp_in), .out(q[0]), .tc(tc[0]),
        .ovf(ovf[0]), .unf(unf[0]), .match(mtch[0])
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_SAT)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .datain(datain), .counten(counten), .inc(inc), .step(step),
        .cmp_we(cmp_we), .cmp_in(cmp_in), .out(q[1]), .tc(tc[1]),
        .ovf(ovf[1]), .unf(unf[1]), .match(mtch[1])
    );

    updown_counter_n #(.WIDTH(4), .MODE(CNT_WRAP)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .datain(datain), .counten(counten), .inc(inc), .step(step),
        .cmp_we(cmp_we), .cmp_in(cmp_in), .out(q[2]), .tc(tc[2]),
        .ovf(ovf[2]), .unf(unf[2]), .match(mtch[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got %0d exp %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_ovf[i] = 0;
            m_unf[i] = 0;
            m_mat[i] = 0;
            m_cmp[i] = MAXS[i];
        end
    endtask

    // Applies the effect of the coming clock edge to the model.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int mx, s, nv;
            mx = MAXS[i];
            m_ovf[i] = 0;
            m_unf[i] = 0;
            m_mat[i] = 0;
            if (clear) begin
                m_out[i] = 0;
            end else if (load) begin
                m_out[i] = lim(int'(datain), mx);
            end else if (counten) begin
                s = int'(step);
                if (inc) begin
                    nv = m_out[i] + s;
                    if (nv > mx) begin
                        m_ovf[i] = 1;
                        nv = SATS[i] ? mx : nv - (mx + 1);
                    end
                end else begin
                    nv = m_out[i] - s;
                    if (nv < 0) begin
                        m_unf[i] = 1;
                        nv = SATS[i] ? 0 : nv + (mx + 1);
                    end
                end
                m_mat[i] = (nv == m_cmp[i]) ? 1 : 0;
                m_out[i] = nv;
            end
            if (cmp_we) m_cmp[i] = lim(int'(cmp_in), MAXS[i]);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            int etc;
            etc = ((inc && m_out[i] == MAXS[i]) ||
                   (!inc && m_out[i] == 0)) ? 1 : 0;
            check($sformatf("out%0d", i), 32'(q[i]), m_out[i]);
            check($sformatf("ovf%0d", i), 32'(ovf[i]), m_ovf[i]);
            check($sformatf("unf%0d", i), 32'(unf[i]), m_unf[i]);
            check($sformatf("match%0d", i), 32'(mtch[i]), m_mat[i]);
            check($sformatf("tc%0d", i), 32'(tc[i]), etc);
        end
    endtask

    task automatic cyc(input bit cl, input bit ld, input bit ce,
                       input bit up, input int st, input int d,
                       input bit cw, input int ci);
        clear   = cl;
        load    = ld;
        counten = ce;
        inc     = up;
        step    = 4'(st);
        datain  = 4'(d);
        cmp_we  = cw;
        cmp_in  = 4'(ci);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        cyc(0, 0, 1, 1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("arst_out%0d", i), 32'(q[i]), 0);
            check($sformatf("arst_ovf%0d", i), 32'(ovf[i]), 0);
            check($sformatf("arst_unf%0d", i), 32'(unf[i]), 0);
            check($sformatf("arst_mat%0d", i), 32'(mtch[i]), 0);
        end
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 0; load = 0; counten = 0; inc = 1;
        cmp_we = 0; datain = 0; step = 0; cmp_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // cmp resets to MAX: 8 -> 9 matches on the first two instances.
        cyc(0, 1, 0, 1, 0, 8, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 12, 0, 0);
        repeat (2) cyc(0, 0, 1, 1, 7, 0, 0, 0);
        // Compare write coinciding with a count uses the old value.
        cyc(0, 0, 1, 1, 1, 0, 1, 5);
        cyc(0, 1, 0, 1, 0, 3, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 5, 0, 0);
        cyc(1, 1, 1, 1, 1, 7, 0, 0);
        cyc(0, 1, 1, 1, 4, 7, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 9, 0, 0, 0);

        for (int k = 0; k < 1500; k++) begin
            if (k == 700) async_reset();
            cyc(($urandom_range(0, 31) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9)
                                            : $urandom_range(0, 2),
                $urandom_range(0, 15),
                ($urandom_range(0, 7) == 0),
                $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised up/down counter that supersedes the fixed 8-bit counter for timer, address-generator and event-count uses. Adds configurable width, modulus, step size, wrap-or-saturate mode, a programmable compare register and registered overflow/underflow/match event pulses. It sits between control FSMs, which drive load/enable/direction, and consumers that need the count value or its event strobes.

## Interface
- WIDTH, 8, counter and data width in bits, minimum 2
- MAX_VAL, 2**WIDTH-1, terminal (modulus-1) value; legal range 1 to 2**WIDTH-1
- MODE, CNT_WRAP, CNT_WRAP = modular wrap; CNT_SAT = saturate at 0 / MAX_VAL
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of datain
- datain  input  WIDTH  load value
- counten  input  1  count enable
- inc  input  1  direction: 1 = up, 0 = down
- step  input  WIDTH  increment magnitude; legal range 0 to MAX_VAL
- cmp_we  input  1  write compare register
- cmp_in  input  WIDTH  compare value
- out  output  WIDTH  current count
- tc  output  1  terminal count, combinational: (inc & out==MAX_VAL) | (!inc & out==0)
- ovf  output  1  one-cycle pulse, up-count crossed MAX_VAL
- unf  output  1  one-cycle pulse, down-count crossed 0
- match  output  1  one-cycle pulse, count step landed on compare value

## Operation
- Priority per edge: rst > clear > load > counten. Lower-priority actions are ignored in that cycle.
- clear: out <= 0. ovf, unf and match are 0 that cycle. cmp is unchanged.
- load: out <= min(datain, MAX_VAL). No event pulses.
- Count up: sum = out + step, computed at WIDTH+1 bits.
  - If sum <= MAX_VAL: out <= sum.
  - Otherwise, WRAP: out <= sum - (MAX_VAL+1). SAT: out <= MAX_VAL.
  - In both modes, ovf = 1 in the overflow case.
- Count down:
  - If step <= out: out <= out - step.
  - Otherwise, WRAP: out <= out + (MAX_VAL+1) - step. SAT: out <= 0.
  - In both modes, unf = 1 in the underflow case.
- step = 0 with counten: out holds. No ovf/unf. match fires if out == cmp.
- SAT mode at a limit: counting further past the limit holds the value and re-asserts ovf/unf on every enabled cycle.
- match = 1 when a count operation (not load or clear) writes a value equal to cmp.
- cmp register:
  - cmp_we writes min(cmp_in, MAX_VAL), independent of the counter priority chain.
  - A compare in the same cycle as cmp_we uses the old cmp value.
- step > MAX_VAL is illegal. The design must carry a simulation assertion; the RTL result is don't-care.

## Timing
- out, ovf, unf, match and cmp are registered. Update latency is 1 clock from the sampling edge.
- Reset values: out = 0, ovf = 0, unf = 0, match = 0, cmp = MAX_VAL.
- rst assertion clears state immediately, without waiting for clk. The first count occurs on the first rising edge after rst deasserts.
- Event pulses last exactly one cycle unless the condition recurs on the next enabled count.
- tc follows out and inc combinationally with no register stage.
- Simultaneous load + counten: load wins and no events fire. Simultaneous clear + load: clear wins.

## Structure
- Shared package counter_pkg:
  - cnt_mode_e enum (CNT_WRAP, CNT_SAT)
  - a localparam helper for the MAX_VAL default
- One natural sub-module: updown_counter_n_next.
  - Combinational next-value/event calculator.
  - Inputs: out, step, inc, MODE, MAX_VAL. Outputs: nxt, ovf_n, unf_n.
  - Unit-testable in isolation.
- Top level contains the priority chain, the registers and the cmp/match logic.

## Test plan
- WIDTH=8, MAX_VAL=255, WRAP, step=1, inc=1, load 254 then count 3 cycles -> out 255, 0 (ovf=1 on this cycle only), 1.
- WIDTH=4, MAX_VAL=9, WRAP, step=3, inc=0, load 1, count once -> out = 1+10-3 = 8, unf=1. Load 12 -> out=9.
- WIDTH=8, MAX_VAL=100, SAT, step=30, inc=1, load 90, count 2 cycles -> out 100, 100, with ovf=1 both cycles. Down from 10 with step 30 -> out 0, unf=1.
- cmp_we with cmp_in=5, load 3, step 1, count up -> match=1 only on the edge out becomes 5. Loading 5 directly -> match stays 0.
- Priority: clear+load+counten together -> out 0. Load+counten -> out=datain, no pulses. step=0 counting -> out constant.
- Assert rst asynchronously mid-count (between edges) -> out, ovf, unf and match go 0 and cmp goes to MAX_VAL before the next edge. Counting resumes from 0 after release.
